// File: rtl/regfile_writeback.sv
// Writeback merge of ALU and load results onto the single regfile write port.
// Latency: one cycle from selection to wb_wren/wb_waddr/wb_wdata; loads may wait in the FIFO while the ALU holds the port.
// Backpressure: ALU is never stalled; load_ready drops when the load FIFO is full (no pop-through).
module regfile_writeback #(
    parameter int LOAD_DEPTH = 4,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  alu_valid,
    input  logic [ADDR_WIDTH-1:0] alu_waddr,
    input  logic [31:0]           alu_wdata,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [ADDR_WIDTH-1:0] load_waddr,
    input  logic [31:0]           load_rdata,
    input  logic [2:0]            load_funct3,
    input  logic [1:0]            load_offset,
    input  logic [ADDR_WIDTH-1:0] query_addr1,
    input  logic [ADDR_WIDTH-1:0] query_addr2,
    output logic                  query_hit,
    output logic                  wb_wren,
    output logic [ADDR_WIDTH-1:0] wb_waddr,
    output logic [31:0]           wb_wdata
);
    localparam int PTR_W = (LOAD_DEPTH > 1) ? $clog2(LOAD_DEPTH) : 1;
    localparam int CNT_W = $clog2(LOAD_DEPTH + 1);

    logic [ADDR_WIDTH-1:0] fifo_addr [LOAD_DEPTH];
    logic [31:0]           fifo_data [LOAD_DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      count;

    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_value;
    logic        load_accept;
    logic        load_nonzero;
    logic        alu_sel;
    logic        fifo_nonempty;
    logic        pop;
    logic        push;
    logic        bypass;

    always_comb begin
        load_byte = 8'(load_rdata >> {load_offset, 3'b000});
        load_half = 16'(load_rdata >> {load_offset[1], 4'b0000});
        case (load_funct3)
            3'b000:  load_value = {{24{load_byte[7]}}, load_byte};
            3'b001:  load_value = {{16{load_half[15]}}, load_half};
            3'b100:  load_value = {24'd0, load_byte};
            3'b101:  load_value = {16'd0, load_half};
            default: load_value = load_rdata;
        endcase
    end

    assign load_ready    = (count != CNT_W'(LOAD_DEPTH));
    assign load_accept   = load_valid && load_ready;
    assign load_nonzero  = (load_waddr[4:0] != 5'd0);
    assign alu_sel       = alu_valid && (alu_waddr[4:0] != 5'd0);
    assign fifo_nonempty = (count != '0);
    assign pop           = !alu_sel && fifo_nonempty;
    // Bypass only when nothing is buffered, so acceptance order is preserved.
    assign bypass        = !alu_sel && !fifo_nonempty && load_accept && load_nonzero;
    assign push          = load_accept && load_nonzero && !bypass;

    always_comb begin
        logic [PTR_W-1:0] rel;
        query_hit = 1'b0;
        for (int i = 0; i < LOAD_DEPTH; i++) begin
            rel = PTR_W'(i) - rd_ptr;
            if (CNT_W'(rel) < count) begin
                if ((query_addr1[4:0] != 5'd0 && fifo_addr[i] == query_addr1) ||
                    (query_addr2[4:0] != 5'd0 && fifo_addr[i] == query_addr2))
                    query_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_addr[wr_ptr] <= load_waddr;
            fifo_data[wr_ptr] <= load_value;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wb_wren  <= 1'b0;
            wb_waddr <= '0;
            wb_wdata <= '0;
        end else begin
            wb_wren <= alu_sel || pop || bypass;
            if (alu_sel) begin
                wb_waddr <= alu_waddr;
                wb_wdata <= alu_wdata;
            end else if (pop) begin
                wb_waddr <= fifo_addr[rd_ptr];
                wb_wdata <= fifo_data[rd_ptr];
            end else if (bypass) begin
                wb_waddr <= load_waddr;
                wb_wdata <= load_value;
            end
        end
    end
endmodule

// File: tb/tb_regfile_writeback.sv
// Scoreboard bench for regfile_writeback: queue-based reference of the load buffer and port arbitration.
module tb_regfile_writeback;
    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        alu_valid;
    logic [9:0]  alu_waddr;
    logic [31:0] alu_wdata;
    logic        load_valid;
    logic        load_ready;
    logic [9:0]  load_waddr;
    logic [31:0] load_rdata;
    logic [2:0]  load_funct3;
    logic [1:0]  load_offset;
    logic [9:0]  query_addr1;
    logic [9:0]  query_addr2;
    logic        query_hit;
    logic        wb_wren;
    logic [9:0]  wb_waddr;
    logic [31:0] wb_wdata;

    regfile_writeback #(.LOAD_DEPTH(DEPTH), .ADDR_WIDTH(10)) dut (
        .clock(clock), .reset_n(reset_n),
        .alu_valid(alu_valid), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata),
        .load_valid(load_valid), .load_ready(load_ready), .load_waddr(load_waddr),
        .load_rdata(load_rdata), .load_funct3(load_funct3), .load_offset(load_offset),
        .query_addr1(query_addr1), .query_addr2(query_addr2), .query_hit(query_hit),
        .wb_wren(wb_wren), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata)
    );

    always #5 clock = ~clock;

    typedef struct { logic [9:0] a; logic [31:0] d; int c; } wr_t;
    typedef struct { logic [9:0] a; logic [31:0] d; } ld_t;
    wr_t expq[$];
    ld_t mq[$];
    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [31:0] ext(input logic [31:0] rd, input logic [2:0] f3, input logic [1:0] off);
        int unsigned b, h;
        b = (rd >> (8 * off)) & 32'hFF;
        h = (rd >> (16 * (off / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return rd;
        endcase
    endfunction

    // Monitor: every regfile write must match the oldest expected write, in the expected cycle.
    always @(posedge clock) begin
        #1;
        while (expq.size() > 0 && expq[0].c < cyc) begin
            checks++; errors++;
            $display("FAIL missing_write: got none, required addr=%h data=%h at cycle %0d", expq[0].a, expq[0].d, expq[0].c);
            void'(expq.pop_front());
        end
        if (reset_n && wb_wren) begin
            checks++;
            if (wb_waddr[4:0] == 5'd0) begin
                errors++;
                $display("FAIL x0_write: got addr=%h, required nonzero reg index", wb_waddr);
            end
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%h data=%h at cycle %0d, required no write", wb_waddr, wb_wdata, cyc);
            end else begin
                wr_t e;
                e = expq.pop_front();
                if (wb_waddr !== e.a || wb_wdata !== e.d || cyc != e.c) begin
                    errors++;
                    $display("FAIL wb_write: got addr=%h data=%h cycle %0d, required addr=%h data=%h cycle %0d",
                             wb_waddr, wb_wdata, cyc, e.a, e.d, e.c);
                end
            end
        end
    end

    task automatic step(input logic av, input logic [9:0] aa, input logic [31:0] ad,
                        input logic lv, input logic [9:0] la, input logic [31:0] lr,
                        input logic [2:0] f3, input logic [1:0] off,
                        input logic [9:0] q1, input logic [9:0] q2);
        logic ready, hit, acc, nz;
        logic [31:0] val;
        @(negedge clock);
        alu_valid = av; alu_waddr = aa; alu_wdata = ad;
        load_valid = lv; load_waddr = la; load_rdata = lr; load_funct3 = f3; load_offset = off;
        query_addr1 = q1; query_addr2 = q2;
        #1;
        ready = (mq.size() < DEPTH);
        checks++;
        if (load_ready !== ready) begin
            errors++;
            $display("FAIL load_ready: got %b, required %b at cycle %0d", load_ready, ready, cyc);
        end
        hit = 1'b0;
        foreach (mq[k]) begin
            if ((q1[4:0] != 5'd0 && mq[k].a == q1) || (q2[4:0] != 5'd0 && mq[k].a == q2)) hit = 1'b1;
        end
        checks++;
        if (query_hit !== hit) begin
            errors++;
            $display("FAIL query_hit: got %b, required %b (q1=%h q2=%h) at cycle %0d", query_hit, hit, q1, q2, cyc);
        end
        acc = lv && ready;
        nz  = (la[4:0] != 5'd0);
        val = ext(lr, f3, off);
        if (av && aa[4:0] != 5'd0) begin
            expq.push_back('{aa, ad, cyc + 1});
            if (acc && nz) mq.push_back('{la, val});
        end else if (mq.size() > 0) begin
            ld_t h;
            h = mq.pop_front();
            expq.push_back('{h.a, h.d, cyc + 1});
            if (acc && nz) mq.push_back('{la, val});
        end else if (acc && nz) begin
            expq.push_back('{la, val, cyc + 1});
        end
    endtask

    task automatic idle(input logic [9:0] q1, input logic [9:0] q2);
        step(1'b0, 10'h0, 32'h0, 1'b0, 10'h0, 32'h0, 3'd0, 2'd0, q1, q2);
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        alu_valid = 1'b0; load_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (wb_wren !== 1'b0 || load_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_pulse: got wren=%b ready=%b, required wren=0 ready=1", wb_wren, load_ready);
        end
        mq.delete();
        expq.delete();
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        alu_valid = 1'b0; alu_waddr = '0; alu_wdata = '0;
        load_valid = 1'b0; load_waddr = '0; load_rdata = '0; load_funct3 = '0; load_offset = '0;
        query_addr1 = '0; query_addr2 = '0;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (wb_wren !== 1'b0 || wb_waddr !== 10'h0 || wb_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: got wren=%b addr=%h data=%h, required all zero", wb_wren, wb_waddr, wb_wdata);
        end
        @(negedge clock);
        reset_n = 1'b1;

        // Signed and unsigned byte extraction through the bypass path.
        step(1'b0, 10'h0, 32'h0, 1'b1, 10'h025, 32'h0000_80FF, 3'b000, 2'd1, 10'h0, 10'h0);
        step(1'b0, 10'h0, 32'h0, 1'b1, 10'h025, 32'h0000_80FF, 3'b100, 2'd1, 10'h0, 10'h0);
        idle(10'h0, 10'h0);

        // ALU owns the port for six cycles while five loads are offered; the fifth must bounce.
        for (int i = 0; i < 6; i++)
            step(1'b1, 10'h061 + 10'(i), 32'hA000_0000 + 32'(i),
                 i < 5, 10'h041 + 10'(i), 32'h1234_5678 + 32'(i), 3'b010, 2'd0, 10'h043, 10'h040);
        for (int i = 0; i < 6; i++) idle(10'h043, 10'h040);

        // ALU x0 result does not block the FIFO head.
        step(1'b1, 10'h066, 32'h0000_0066, 1'b1, 10'h055, 32'hFFFF_8001, 3'b101, 2'd2, 10'h055, 10'h0);
        step(1'b1, 10'h020, 32'hDEAD_BEEF, 1'b0, 10'h0, 32'h0, 3'd0, 2'd0, 10'h055, 10'h0);
        idle(10'h055, 10'h0);

        // Load to x0 with the FIFO empty is accepted and dropped.
        step(1'b0, 10'h0, 32'h0, 1'b1, 10'h000, 32'hCAFE_F00D, 3'b010, 2'd0, 10'h0, 10'h0);
        idle(10'h0, 10'h0);

        // Fill the FIFO, then reset mid-cycle; nothing buffered may leak out.
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, 10'h070 + 10'(i), 32'(i), 1'b1, 10'h0A1 + 10'(i), 32'h8765_4321, 3'b001, 2'(i), 10'h0A1, 10'h0);
        pulse_reset();
        for (int i = 0; i < 4; i++) idle(10'h0A1, 10'h0A2);

        for (int n = 0; n < 600; n++) begin
            logic av, lv;
            logic [9:0] aa, la, q1, q2;
            av = ($urandom_range(0, 99) < 55);
            aa = {5'($urandom), ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom)};
            lv = ($urandom_range(0, 99) < 70);
            la = {5'($urandom), ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom)};
            q1 = 10'($urandom);
            q2 = 10'($urandom);
            if (mq.size() > 0 && $urandom_range(0, 1) == 1) q1 = mq[$urandom_range(0, mq.size() - 1)].a;
            if (mq.size() > 0 && $urandom_range(0, 2) == 0) q2 = {mq[0].a[9:5], 5'd0};
            step(av, aa, $urandom, lv, la, $urandom, 3'($urandom), 2'($urandom), q1, q2);
            if (n == 300) pulse_reset();
        end

        for (int i = 0; i < 20 && (mq.size() > 0 || expq.size() > 0); i++) idle(10'h0, 10'h0);
        idle(10'h0, 10'h0);
        @(posedge clock);
        #2;
        checks++;
        if (mq.size() != 0 || expq.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d buffered and %0d pending writes, required 0 and 0", mq.size(), expq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Writeback stage directly upstream of the regfile's single write port (waddr/wdata/wren).
- Merges two result sources into that one port:
  - ALU results: fixed latency, no backpressure, always win arbitration.
  - Memory load results: valid/ready handshake, aligned and extended here, buffered in a small FIFO while the ALU holds the port.
- Gives the issue stage a load-pending hazard query.
- Register address is {hart[4:0], reg[4:0]}.

Parameters:
- LOAD_DEPTH, 4, load FIFO entries (power of two, ≥2).
- ADDR_WIDTH, 10, regfile address width; low 5 bits are the architectural register index.

Ports:
- clock  input  1  global clock, all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- alu_valid  input  1  ALU result present this cycle.
- alu_waddr  input  ADDR_WIDTH  ALU destination address.
- alu_wdata  input  32  ALU result.
- load_valid  input  1  load result offered.
- load_ready  output  1  FIFO can accept; transfer when load_valid && load_ready.
- load_waddr  input  ADDR_WIDTH  load destination address.
- load_rdata  input  32  raw aligned memory word.
- load_funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- load_offset  input  2  byte address bits [1:0].
- query_addr1  input  ADDR_WIDTH  hazard query for the rs1 operand.
- query_addr2  input  ADDR_WIDTH  hazard query for the rs2 operand.
- query_hit  output  1  a queried register has a load still buffered.
- wb_wren  output  1  regfile write enable.
- wb_waddr  output  ADDR_WIDTH  regfile write address.
- wb_wdata  output  32  regfile write data.

Behaviour:
- Reset (asynchronous, reset_n low):
  - wb_wren=0, wb_waddr=0, wb_wdata=0.
  - FIFO empty (count=0, read and write pointers 0).
  - load_ready=1 once reset is released.
  - Asserting reset mid-operation discards all buffered loads immediately.
- Outputs: wb_wren, wb_waddr and wb_wdata are registered, so a result is written to the regfile one cycle after it is selected here.
- Load extraction, performed at enqueue time (the FIFO stores the final value):
  - Byte = rdata >> (offset*8).
  - Half = rdata >> (offset[1]*16); offset[0] is ignored.
  - LB and LH sign-extend; LBU and LHU zero-extend.
  - LW and every undefined funct3 pass the full word unmodified.
- x0 suppression:
  - Any source whose address[4:0]==0 never produces wb_wren=1.
  - An ALU x0 result counts as "no ALU result" for arbitration.
  - A load to x0 is accepted (handshake completes) but not enqueued.
- load_ready = (count < LOAD_DEPTH), taken from registered count. There is no same-cycle pop-through when full.
- Per-cycle selection, first match wins:
  1. ALU valid and not x0: emit the ALU result. The FIFO holds. An accepted load is enqueued.
  2. FIFO non-empty: pop the head and emit it. An accepted load is enqueued in the same cycle. Count is unchanged if both a pop and a push occur.
  3. FIFO empty and a non-x0 load is accepted: bypass, emit it directly with no FIFO write.
  4. Otherwise: wb_wren=0. wb_waddr and wb_wdata hold their previous values.
- Ordering: loads retire in acceptance order. ALU results are never reordered against each other.
- query_hit (combinational):
  - Asserts if query_addr1 or query_addr2 equals the address of any valid FIFO entry.
  - Queries with reg index 0 never hit.
  - The wb output register and bypass loads are not reported; regfile write-forwarding covers them.
- Pointers wrap modulo LOAD_DEPTH. Count ranges 0..LOAD_DEPTH with no overflow: a push is impossible when full.

Test Plan:
1. Reset, then LB with rdata=0x0000_80FF, offset=1, waddr=0x025, no ALU:
   - Next cycle wb_wren=1, waddr=0x025, wdata=0xFFFF_FF80.
   - With funct3=100, wdata=0x0000_0080.
2. ALU valid on every cycle 0–5 while loads A,B,C,D,E are offered on cycles 0–4:
   - A–D are accepted; load_ready=0 on cycle 4, so E is not accepted.
   - Cycles 1–6: ALU writes.
   - Cycles 7–10: loads A,B,C,D written in order.
3. FIFO holds load to 0x043 and query_addr1=0x043:
   - query_hit=1 until the cycle that entry is popped, then 0.
   - query_addr2=0x040 never hits.
4. ALU to 0x020 (x0 of hart 1) valid while FIFO holds one entry:
   - The entry is popped and written the same cycle.
   - No write to 0x020 is ever seen.
5. Load to 0x000 accepted with FIFO empty: handshake completes, wb_wren stays 0, count stays 0.
6. FIFO full (4 entries), reset_n pulsed low mid-cycle:
   - wb_wren=0 and load_ready=1 immediately after release.
   - No stale entry is ever written.
